decode_stage: RTL
=================

# decode_stage

RV32E instruction decode stage sitting directly downstream of instruction fetch. It accepts a raw 32-bit instruction word and its PC over a valid/ready handshake, and decodes register indices, sign-extended immediate, ALU operation and control flags. It flags illegal encodings, including any use of x16–x31. It presents the result to execute through a registered output with a one-entry skid, so neither side sees combinational ready paths through it.

## Interface
- Parameters: none.
- Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage can accept; equals !skid_valid (registered state only)
- in_instr  in  32  raw instruction word
- in_pc  in  32  address of in_instr
- out_valid  out  1  decoded packet present
- out_ready  in  1  execute accepts packet
- out_pc  out  32  PC of the decoded instruction
- out_rd, out_rs1, out_rs2  out  4 each  register indices (x0–x15)
- out_imm  out  32  sign-extended immediate (I/S/B/U/J by format; 0 for R)
- out_funct3  out  3  instr[14:12] passed through
- out_alu_op  out  4  ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9
- out_alu_src_imm  out  1  ALU operand B is out_imm
- out_reg_write, out_mem_read, out_mem_write, out_branch, out_jal, out_jalr, out_auipc, out_fence, out_ecall, out_ebreak  out  1 each  control flags
- out_illegal  out  1  instruction is illegal

## Operation
- Decoding is combinational on in_instr; results are captured into the output register or skid register. Output ports come straight from the output register.
- LUI: rs1 forced to 0, alu ADD, src_imm=1, reg_write=1.
- AUIPC: auipc=1, alu ADD, reg_write=1.
- OP-IMM and OP: alu_op from funct3/funct7. SUB and SRA/SRAI require funct7=0100000. Any other funct7 other than 0000000 is illegal (for OP-IMM, applies only to shifts).
- LOAD: funct3 must be in {0,1,2,4,5}; mem_read=1, reg_write=1, alu ADD.
- STORE: funct3 must be in {0,1,2}; mem_write=1, alu ADD.
- BRANCH: funct3 2 and 3 are illegal; branch=1, alu SUB.
- JAL: jal=1, reg_write=1.
- JALR: funct3 must be 0; jalr=1, reg_write=1.
- MISC-MEM: fence=1, no other flags.
- SYSTEM: only 0x00000073 (ecall=1) and 0x00100073 (ebreak=1) are legal.
- Illegal when any of the following holds:
  - instr[1:0]≠11
  - unknown opcode
  - a rule above is violated
  - bit 4 of any register field that the format uses is set
- Illegal packets still flow with out_illegal=1. All other control flags, reg indices and alu_op are 0; out_pc is valid. The packet consumes one slot.
- Registers: output register (out_valid + payload) and skid register (skid_valid + payload).
- Accept condition: in_valid && in_ready.
- Output advance condition: !out_valid || out_ready.
- Accept with output advance true, skid empty: instruction goes to the output register.
- Output advance true, skid full: skid moves to the output register and skid empties. in_ready was 0, so nothing is accepted.
- Accept with output advance false: instruction goes to skid. in_ready drops the next cycle.
- Output advance true with no accept and skid empty: out_valid clears.
- Order is strictly preserved: no loss, no duplication.

## Timing
- Reset: out_valid=0, skid_valid=0, all payload registers 0, in_ready=1, out_illegal=0. Effective immediately (asynchronous).
- Reset mid-operation discards both held packets with no partial state.
- Latency: an instruction accepted in cycle N is visible on outputs in cycle N+1.
- Throughput: 1 instruction/cycle while out_ready=1.
- in_ready depends only on registered state, never on out_ready or in_valid in the same cycle.
- out_valid, once raised, holds with a stable payload until out_ready is sampled high.
- Capacity: 2 instructions (output + skid). in_ready=0 only when both are full.

## Test plan
- ADDI x1,x0,5 (0x00500093), out_ready=1 → next cycle out_valid=1, rd=1, rs1=0, imm=0x00000005, alu_op=0, src_imm=1, reg_write=1, illegal=0.
- BEQ x0,x0,-4 (0xFE000EE3) → imm=0xFFFFFFFC, branch=1, alu_op=1, funct3=0, reg_write=0.
- LW x5,-8(x2) (0xFF812283) → rs1=2, rd=5, imm=0xFFFFFFF8, mem_read=1, reg_write=1.
- ADD x16,x1,x2 (0x00208833) and word 0x00000000 → illegal=1, all other flags 0; each packet occupies one slot.
- Backpressure: out_ready=0, offer A, B, C back-to-back → A, B accepted; in_ready=0 from the cycle after B's accept; C is held. Raise out_ready → A, B, C emerge on consecutive cycles, in order.
- Assert reset while out_valid=1 and skid full → out_valid=0 and in_ready=1 immediately. After release, the first new instruction appears one cycle after its accept.

Source files
------------

// File: rtl/decode_stage.sv
// RV32E decode stage: combinational decode of the fetched word into a registered
// output slot backed by a one-entry skid, so in_ready depends only on local state.
module decode_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [3:0]  out_rd,
    output logic [3:0]  out_rs1,
    output logic [3:0]  out_rs2,
    output logic [31:0] out_imm,
    output logic [2:0]  out_funct3,
    output logic [3:0]  out_alu_op,
    output logic        out_alu_src_imm,
    output logic        out_reg_write,
    output logic        out_mem_read,
    output logic        out_mem_write,
    output logic        out_branch,
    output logic        out_jal,
    output logic        out_jalr,
    output logic        out_auipc,
    output logic        out_fence,
    output logic        out_ecall,
    output logic        out_ebreak,
    output logic        out_illegal
);

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [31:0] imm;
        logic [2:0]  funct3;
        logic [3:0]  alu_op;
        logic        src_imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        auipc;
        logic        fence;
        logic        ecall;
        logic        ebreak;
        logic        illegal;
    } pkt_t;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpMisc   = 7'b0001111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluSll  = 4'd2;
    localparam logic [3:0] AluSlt  = 4'd3;
    localparam logic [3:0] AluSltu = 4'd4;
    localparam logic [3:0] AluXor  = 4'd5;
    localparam logic [3:0] AluSrl  = 4'd6;
    localparam logic [3:0] AluSra  = 4'd7;
    localparam logic [3:0] AluOr   = 4'd8;
    localparam logic [3:0] AluAnd  = 4'd9;

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [3:0]  arith_op;
    logic        use_rd, use_rs1, use_rs2, bad;
    pkt_t        dec;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
    assign imm_u  = {in_instr[31:12], 12'h000};
    assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};

    // funct7[5] selects SUB only for register-register ops; ADDI has no subtract form.
    always_comb begin
        arith_op = AluAdd;
        case (funct3)
            3'd0:    arith_op = (opcode == OpReg && funct7[5]) ? AluSub : AluAdd;
            3'd1:    arith_op = AluSll;
            3'd2:    arith_op = AluSlt;
            3'd3:    arith_op = AluSltu;
            3'd4:    arith_op = AluXor;
            3'd5:    arith_op = funct7[5] ? AluSra : AluSrl;
            3'd6:    arith_op = AluOr;
            default: arith_op = AluAnd;
        endcase
    end

    always_comb begin
        dec        = '0;
        use_rd     = 1'b0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        bad        = 1'b0;
        case (opcode)
            OpLui: begin
                use_rd = 1'b1; dec.imm = imm_u; dec.src_imm = 1'b1; dec.reg_write = 1'b1;
            end
            OpAuipc: begin
                use_rd = 1'b1; dec.imm = imm_u; dec.src_imm = 1'b1; dec.reg_write = 1'b1;
                dec.auipc = 1'b1;
            end
            OpJal: begin
                use_rd = 1'b1; dec.imm = imm_j; dec.jal = 1'b1; dec.reg_write = 1'b1;
            end
            OpJalr: begin
                use_rd = 1'b1; use_rs1 = 1'b1; dec.imm = imm_i; dec.src_imm = 1'b1;
                dec.jalr = 1'b1; dec.reg_write = 1'b1; bad = (funct3 != 3'd0);
            end
            OpBranch: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; dec.imm = imm_b; dec.branch = 1'b1;
                dec.alu_op = AluSub; bad = (funct3[2:1] == 2'b01);
            end
            OpLoad: begin
                use_rd = 1'b1; use_rs1 = 1'b1; dec.imm = imm_i; dec.src_imm = 1'b1;
                dec.mem_read = 1'b1; dec.reg_write = 1'b1;
                bad = (funct3 == 3'd3) || (funct3[2:1] == 2'b11);
            end
            OpStore: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; dec.imm = imm_s; dec.src_imm = 1'b1;
                dec.mem_write = 1'b1; bad = funct3[2] || (funct3[1:0] == 2'b11);
            end
            OpImm: begin
                use_rd = 1'b1; use_rs1 = 1'b1; dec.imm = imm_i; dec.src_imm = 1'b1;
                dec.reg_write = 1'b1; dec.alu_op = arith_op;
                bad = ((funct3 == 3'd1) && (funct7 != 7'h00)) ||
                      ((funct3 == 3'd5) && (funct7 != 7'h00) && (funct7 != 7'h20));
            end
            OpReg: begin
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; dec.reg_write = 1'b1;
                dec.alu_op = arith_op;
                bad = (funct7 != 7'h00) &&
                      !((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
            end
            OpMisc: dec.fence = 1'b1;
            OpSystem: begin
                dec.ecall  = (in_instr == 32'h0000_0073);
                dec.ebreak = (in_instr == 32'h0010_0073);
                bad        = !(dec.ecall || dec.ebreak);
            end
            // Every known opcode ends in 2'b11, so a bad low pair also lands here.
            default: bad = 1'b1;
        endcase
        if ((use_rd && in_instr[11]) || (use_rs1 && in_instr[19]) ||
            (use_rs2 && in_instr[24])) begin
            bad = 1'b1;
        end
        dec.rd  = use_rd  ? in_instr[10:7]  : 4'd0;
        dec.rs1 = use_rs1 ? in_instr[18:15] : 4'd0;
        dec.rs2 = use_rs2 ? in_instr[23:20] : 4'd0;
        if (bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
        dec.pc     = in_pc;
        dec.funct3 = funct3;
    end

    logic out_valid_d, out_valid_q, skid_valid_d, skid_valid_q;
    pkt_t out_d, out_q, skid_d, skid_q;
    logic accept, advance;

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign advance  = !out_valid_q || out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (advance) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_pc          = out_q.pc;
    assign out_rd          = out_q.rd;
    assign out_rs1         = out_q.rs1;
    assign out_rs2         = out_q.rs2;
    assign out_imm         = out_q.imm;
    assign out_funct3      = out_q.funct3;
    assign out_alu_op      = out_q.alu_op;
    assign out_alu_src_imm = out_q.src_imm;
    assign out_reg_write   = out_q.reg_write;
    assign out_mem_read    = out_q.mem_read;
    assign out_mem_write   = out_q.mem_write;
    assign out_branch      = out_q.branch;
    assign out_jal         = out_q.jal;
    assign out_jalr        = out_q.jalr;
    assign out_auipc       = out_q.auipc;
    assign out_fence       = out_q.fence;
    assign out_ecall       = out_q.ecall;
    assign out_ebreak      = out_q.ebreak;
    assign out_illegal     = out_q.illegal;

endmodule
